prog_loader: RTL and testbench

- Boot-time program loader upstream of the processor data path.
- Receives a byte-stream program frame, assembles 16-bit instruction words and writes them into instruction memory at consecutive 12-bit addresses.
- On a valid checksum, issues the single-cycle `go` pulse that starts the data path; on any frame fault it flags `err` and withholds `go`.

---
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a byte-stream frame into 16-bit words,
// writes them to instruction memory and pulses go when the frame checksum holds.
module prog_loader #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int                TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              go,
    output logic              busy,
    output logic              err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_W_HI   = 3'd2,
        S_W_LO   = 3'd3,
        S_CSUM   = 3'd4,
        S_GO     = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        cnt_hi_r, cnt_hi_s;
    logic [11:0]       word_n_r, word_n_s;
    logic [11:0]       idx_r, idx_s;
    logic [7:0]        hi_r, hi_s;
    logic [7:0]        csum_r, csum_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              err_r, err_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              go_r, busy_r, ready_r;
    logic              xfer_s, waiting_s, tmo_hit_s;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign xfer_s    = rx_valid && ready_r;
    // Timeout only runs while a frame is open and not in the one-cycle GO state.
    assign waiting_s = (state_r != S_IDLE) && (state_r != S_GO);
    assign tmo_hit_s = waiting_s && !xfer_s && (tmo_r == TMO_W'(TIMEOUT));

    // Next-state and datapath update logic.
    always_comb begin
        state_s  = state_r;
        cnt_hi_s = cnt_hi_r;
        word_n_s = word_n_r;
        idx_s    = idx_r;
        hi_s     = hi_r;
        csum_s   = csum_r;
        tmo_s    = tmo_r;
        err_s    = err_r;
        we_s     = 1'b0;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        if (tmo_hit_s) begin
            err_s   = 1'b1;
            state_s = S_IDLE;
            tmo_s   = {TMO_W{1'b0}};
        end else if (xfer_s) begin
            tmo_s = {TMO_W{1'b0}};
            case (state_r)
                S_IDLE: begin
                    cnt_hi_s = rx_data[3:0];
                    csum_s   = rx_data;
                    if (rx_data[7:4] != 4'h0) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        err_s   = 1'b0;
                        state_s = S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    csum_s   = csum_add(csum_r, rx_data);
                    word_n_s = {cnt_hi_r, rx_data};
                    idx_s    = 12'd0;
                    if ({cnt_hi_r, rx_data} == 12'd0) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_W_HI;
                    end
                end
                S_W_HI: begin
                    csum_s  = csum_add(csum_r, rx_data);
                    hi_s    = rx_data;
                    state_s = S_W_LO;
                end
                S_W_LO: begin
                    csum_s  = csum_add(csum_r, rx_data);
                    we_s    = 1'b1;
                    wdata_s = DATA_W'({hi_r, rx_data});
                    addr_s  = BASE_ADDR + ADDR_W'(idx_r);
                    idx_s   = idx_r + 12'd1;
                    if ((idx_r + 12'd1) == word_n_r) begin
                        state_s = S_CSUM;
                    end else begin
                        state_s = S_W_HI;
                    end
                end
                S_CSUM: begin
                    if (rx_data == csum_r) begin
                        state_s = S_GO;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            if (waiting_s) begin
                tmo_s = tmo_r + TMO_W'(1);
            end else begin
                tmo_s = {TMO_W{1'b0}};
            end
            if (state_r == S_GO) begin
                state_s = S_IDLE;
            end else begin
                state_s = state_r;
            end
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_hi_r <= 4'h0;
            word_n_r <= 12'd0;
            idx_r    <= 12'd0;
            hi_r     <= 8'h00;
            csum_r   <= 8'h00;
            tmo_r    <= {TMO_W{1'b0}};
            err_r    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            go_r     <= 1'b0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_hi_r <= cnt_hi_s;
            word_n_r <= word_n_s;
            idx_r    <= idx_s;
            hi_r     <= hi_s;
            csum_r   <= csum_s;
            tmo_r    <= tmo_s;
            err_r    <= err_s;
            we_r     <= we_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            go_r     <= (state_s == S_GO);
            busy_r   <= (state_s != S_IDLE);
            ready_r  <= (state_s != S_GO);
        end
    end

    assign rx_ready   = ready_r;
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign go         = go_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (base 0x000 and 0xFFF) share
// one byte stream; expected writes are queued as frames are driven.
module tb_prog_loader;

    logic        clk, rst_n, rx_valid;
    logic [7:0]  rx_data;
    logic        rdy_a, we_a, go_a, busy_a, err_a;
    logic        rdy_b, we_b, go_b, busy_b, err_b;
    logic [11:0] addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int go_cnt_a = 0;
    int go_cnt_b = 0;
    logic prev_we_a = 1'b0, prev_we_b = 1'b0, prev_go_a = 1'b0;
    logic [27:0] qa[$];
    logic [27:0] qb[$];
    logic [27:0] exp_a, exp_b;
    logic [15:0] words[8];

    prog_loader #(.BASE_ADDR(12'h000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .go(go_a), .busy(busy_a), .err(err_a)
    );

    prog_loader #(.BASE_ADDR(12'hFFF)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .go(go_b), .busy(busy_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write and go monitor: pops the scoreboard on every imem_we.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_a) begin
                checks++;
                if (prev_we_a) begin
                    errors++;
                    $display("FAIL we_a_width imem_we high two cycles in a row");
                end else if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL wr_a unexpected write got %h:%h expected none", addr_a, wdata_a);
                end else begin
                    exp_a = qa.pop_front();
                    if ({addr_a, wdata_a} !== exp_a)
                        begin errors++; $display("FAIL wr_a got %h:%h expected %h:%h", addr_a, wdata_a, exp_a[27:16], exp_a[15:0]); end
                end
            end
            if (we_b) begin
                checks++;
                if (prev_we_b) begin
                    errors++;
                    $display("FAIL we_b_width imem_we high two cycles in a row");
                end else if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL wr_b unexpected write got %h:%h expected none", addr_b, wdata_b);
                end else begin
                    exp_b = qb.pop_front();
                    if ({addr_b, wdata_b} !== exp_b)
                        begin errors++; $display("FAIL wr_b got %h:%h expected %h:%h", addr_b, wdata_b, exp_b[27:16], exp_b[15:0]); end
                end
            end
            if (go_a && prev_go_a) begin
                checks++; errors++;
                $display("FAIL go_width go high two cycles in a row");
            end
            if (go_a) go_cnt_a++;
            if (go_b) go_cnt_b++;
            prev_we_a = we_a;
            prev_we_b = we_b;
            prev_go_a = go_a;
        end else begin
            prev_we_a = 1'b0;
            prev_we_b = 1'b0;
            prev_go_a = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rdy_a !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL rx_ready_wait got 0 for 100 cycles expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n, input logic [7:0] csum_delta);
        logic [11:0] cnt;
        logic [7:0]  sum;
        logic [15:0] w;
        cnt = n[11:0];
        sum = {4'h0, cnt[11:8]} + cnt[7:0];
        send_byte({4'h0, cnt[11:8]});
        send_byte(cnt[7:0]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            sum = sum + w[15:8] + w[7:0];
            send_byte(w[15:8]);
            qa.push_back({12'(i), w});
            qb.push_back({12'hFFF + 12'(i), w});
            send_byte(w[7:0]);
        end
        send_byte(sum + csum_delta);
        rx_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending writes outstanding a=%0d b=%0d expected 0", name, qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({rdy_a, we_a, addr_a, wdata_a, go_a, busy_a, err_a} !== 33'd0)
            begin errors++; $display("FAIL reset_outputs got %h expected 0", {rdy_a, we_a, addr_a, wdata_a, go_a, busy_a, err_a}); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdy_a, busy_a, err_a, go_a} !== 4'b1000)
            begin errors++; $display("FAIL idle_flags got %b expected 1000", {rdy_a, busy_a, err_a, go_a}); end
    endtask

    task automatic test_good_frame;
        int g;
        g = go_cnt_a;
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        send_frame(2, 8'h00);
        checks++;
        if (go_a !== 1'b1 || go_b !== 1'b1 || err_a !== 1'b0)
            begin errors++; $display("FAIL good_go got go=%b/%b err=%b expected 1/1 0", go_a, go_b, err_a); end
        @(posedge clk); #1;
        checks++;
        if (go_a !== 1'b0 || busy_a !== 1'b0)
            begin errors++; $display("FAIL good_after got go=%b busy=%b expected 0 0", go_a, busy_a); end
        drain_check("good");
        checks++;
        if (go_cnt_a - g != 1)
            begin errors++; $display("FAIL good_go_count got %0d expected 1", go_cnt_a - g); end
    endtask

    task automatic test_bad_csum;
        int g;
        g = go_cnt_a;
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        send_frame(2, 8'h01);
        drain_check("badcs");
        checks++;
        if (err_a !== 1'b1 || err_b !== 1'b1 || busy_a !== 1'b0 || go_cnt_a != g)
            begin errors++; $display("FAIL badcs_err got err=%b busy=%b go=%0d expected 1 0 0", err_a, busy_a, go_cnt_a - g); end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (err_a !== 1'b1)
            begin errors++; $display("FAIL badcs_sticky got %b expected 1", err_a); end
    endtask

    task automatic test_bad_count;
        send_byte(8'h00);
        checks++;
        if (err_a !== 1'b0 || busy_a !== 1'b1)
            begin errors++; $display("FAIL cnthi_clear got err=%b busy=%b expected 0 1", err_a, busy_a); end
        send_byte(8'h00);
        rx_valid = 1'b0;
        checks++;
        if (err_a !== 1'b1 || busy_a !== 1'b0)
            begin errors++; $display("FAIL zero_cnt got err=%b busy=%b expected 1 0", err_a, busy_a); end
        send_byte(8'h10);
        rx_valid = 1'b0;
        checks++;
        if (err_a !== 1'b1 || busy_a !== 1'b0)
            begin errors++; $display("FAIL cnthi_nibble got err=%b busy=%b expected 1 0", err_a, busy_a); end
        drain_check("badcnt");
    endtask

    task automatic test_back_to_back;
        int t0, g;
        g = go_cnt_b;
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom_range(0, 65535));
        t0 = cyc;
        send_frame(3, 8'h00);
        checks++;
        if (cyc - t0 != 9)
            begin errors++; $display("FAIL b2b_cycles got %0d expected 9", cyc - t0); end
        checks++;
        if (go_b !== 1'b1 || err_b !== 1'b0)
            begin errors++; $display("FAIL b2b_go got go=%b err=%b expected 1 0", go_b, err_b); end
        drain_check("b2b");
        checks++;
        if (go_cnt_b - g != 1)
            begin errors++; $display("FAIL b2b_go_count got %0d expected 1", go_cnt_b - g); end
    endtask

    task automatic test_timeout;
        int n, g;
        g = go_cnt_a;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        rx_valid = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 1200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n < 1000 || n > 1030)
            begin errors++; $display("FAIL tmo_cycles got %0d expected about 1024", n); end
        checks++;
        if (err_a !== 1'b1 || busy_a !== 1'b0 || go_cnt_a != g)
            begin errors++; $display("FAIL tmo_err got err=%b busy=%b expected 1 0", err_a, busy_a); end
        words[0] = 16'h0007;
        send_frame(1, 8'h00);
        checks++;
        if (go_a !== 1'b1 || err_a !== 1'b0)
            begin errors++; $display("FAIL tmo_recover got go=%b err=%b expected 1 0", go_a, err_a); end
        drain_check("tmo");
    endtask

    task automatic test_reset_midframe;
        int g;
        g = go_cnt_a;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        qa.push_back({12'h000, 16'h1122});
        qb.push_back({12'hFFF, 16'h1122});
        send_byte(8'h22);
        send_byte(8'h33);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy_a, we_a, addr_a, wdata_a, go_a, busy_a, err_a} !== 33'd0)
            begin errors++; $display("FAIL rst_mid got %h expected 0", {rdy_a, we_a, addr_a, wdata_a, go_a, busy_a, err_a}); end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (go_cnt_a != g || busy_a !== 1'b0)
            begin errors++; $display("FAIL rst_after got go=%0d busy=%b expected 0 0", go_cnt_a - g, busy_a); end
        drain_check("rst");
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset;
        test_good_frame;
        test_bad_csum;
        test_bad_count;
        test_back_to_back;
        test_timeout;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
